// File: rtl/conv7seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv7seg_pkg
// Description : Shared constants, state encoding and the digit-to-segment
//               table for the sequential BCD / 7-segment converter.
// Revision    : 1.0 - initial release
// ============================================================================
package conv7seg_pkg;

  // FSM encoding (explicit width)
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ABS   = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_LOAD  = 2'd3;

  // Active-low segment patterns, bit order gfedcba
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Decimal digit to segment code; non-decimal nibbles render blank
  function automatic logic [6:0] seg_of_digit(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_add3_digit.sv
`default_nettype none
// ============================================================================
// Module      : bcd_add3_digit
// Description : Combinational double-dabble nibble adjust: adds 3 to a BCD
//               nibble of 5 or more so the following left shift carries
//               correctly into the next decimal digit.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_add3_digit (
  input  logic [3:0] i_nibble,
  output logic [3:0] o_nibble
);

  assign o_nibble = (i_nibble >= 4'd5) ? (i_nibble + 4'd3) : i_nibble;

endmodule
`default_nettype wire

// File: rtl/conversor_bcd_7seg_seq.sv
`default_nettype none
// ============================================================================
// Module      : conversor_bcd_7seg_seq
// Description : Iterative binary to DIGITS x 7-segment converter using the
//               shift-add-3 algorithm, one input bit per clock. Displays are
//               updated atomically once per conversion; a conversion that
//               does not fit shows dashes and raises overflow.
//               Optional build macro CONV7SEG_SIGNED_EN: two's-complement
//               input with an extra ABS state and a leading sign glyph.
// Revision    : 1.0 - initial release
// ============================================================================
module conversor_bcd_7seg_seq #(
  parameter int WIDTH    = 32,
  parameter int DIGITS   = 8,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      entrada,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   displays
);

  import conv7seg_pkg::*;

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]    bin_q, bin_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic                ovf_q, ovf_d;
  logic                done_q, done_d;
  logic                overflow_q, overflow_d;
  logic [7*DIGITS-1:0] displays_q, displays_d;

  logic [BCD_W-1:0]    bcd_adj_w;
  logic [7*DIGITS-1:0] seg_w;
  logic [3:0]          msd_w;
  logic                ovf_all_w;
  logic                neg_w;

`ifdef CONV7SEG_SIGNED_EN
  logic neg_q, neg_d;
  assign neg_w = neg_q;
  // A negative magnitude needs one display for the sign glyph
  assign ovf_all_w = ovf_q | (neg_q & (bcd_q[BCD_W-1 -: 4] != 4'd0));
`else
  assign neg_w     = 1'b0;
  assign ovf_all_w = ovf_q;
`endif

  // Per-digit add-3 adjust ahead of each shift
  generate
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
      bcd_add3_digit u_add3 (
        .i_nibble (bcd_q[4*g +: 4]),
        .o_nibble (bcd_adj_w[4*g +: 4])
      );
    end
  endgenerate

  // Segment image of the finished BCD value: blanking, sign and overflow dashes
  always_comb begin
    msd_w = 4'd0;
    seg_w = {DIGITS{SEG_BLANK}};
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] != 4'd0) msd_w = 4'(i);
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (ovf_all_w) begin
        seg_w[7*i +: 7] = SEG_DASH;
      end else if (neg_w && ((BLANK_LZ != 0) ? (4'(i) == msd_w + 4'd1)
                                             : (i == DIGITS - 1))) begin
        seg_w[7*i +: 7] = SEG_DASH;
      end else if ((BLANK_LZ != 0) && (4'(i) > msd_w)) begin
        seg_w[7*i +: 7] = SEG_BLANK;
      end else begin
        seg_w[7*i +: 7] = seg_of_digit(bcd_q[4*i +: 4]);
      end
    end
  end

  // FSM and datapath next-state
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;
    displays_d = displays_q;
`ifdef CONV7SEG_SIGNED_EN
    neg_d      = neg_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          bin_d = entrada;
          bcd_d = '0;
          ovf_d = 1'b0;
          cnt_d = '0;
`ifdef CONV7SEG_SIGNED_EN
          neg_d   = entrada[WIDTH-1];
          state_d = S_ABS;
`else
          state_d = S_SHIFT;
`endif
        end
      end
`ifdef CONV7SEG_SIGNED_EN
      S_ABS: begin
        // -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude
        if (neg_q) bin_d = -bin_q;
        state_d = S_SHIFT;
      end
`endif
      S_SHIFT: begin
        ovf_d          = ovf_q | bcd_adj_w[BCD_W-1];
        {bcd_d, bin_d} = {bcd_adj_w, bin_q} << 1;
        cnt_d          = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = S_LOAD;
      end
      S_LOAD: begin
        displays_d = seg_w;
        overflow_d = ovf_all_w;
        done_d     = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bin_q      <= '0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      displays_q <= {DIGITS{SEG_BLANK}};
`ifdef CONV7SEG_SIGNED_EN
      neg_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      displays_q <= displays_d;
`ifdef CONV7SEG_SIGNED_EN
      neg_q      <= neg_d;
`endif
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign overflow = overflow_q;
  assign displays = displays_q;

endmodule
`default_nettype wire
